sum_ip_axil_slave: RTL and testbench

AXI4-Lite responder for the sum_ip register bank. It accepts writes and reads from the AXI VIP master or from the PS interconnect, and it holds four read/write operand/scratch registers. It also provides a registered 32-bit adder result, exported as read-only registers and as a direct output port. It sits inside sum_ip_v1_0 as the S00_AXI endpoint.

---
 rtl/sum_ip_axil_slave.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sum_ip_axil_slave.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_ip_axil_slave.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// sum_ip_axil_slave
//
// Purpose:
//   AXI4-Lite responder for the sum_ip register bank (S00_AXI endpoint inside
//   sum_ip_v1_0). It holds four RW operand/scratch registers and a registered
//   33-bit adder result REG0+REG1. The result is readable over the bus and is
//   also exported directly on sum_out/carry_out.
//
// Register map (byte address, index = ADDR[4:2], ADDR[1:0] ignored):
//   0x00 REG0   RW  operand A
//   0x04 REG1   RW  operand B
//   0x08 REG2   RW  scratch
//   0x0C REG3   RW  scratch
//   0x10 SUM    RO  equals sum_out
//   0x14 STATUS RO  bit0 = carry_out, bits 31:1 = 0
//   0x18, 0x1C  unmapped: writes discarded, reads return 0
//
// Build option:
//   SUM_IP_SLVERR_EN  when defined, unmapped accesses answer SLVERR (2'b10);
//                     otherwise they answer OKAY. Mapped addresses always
//                     answer OKAY.
//
// Ports:
//   ACLK, ARESET          clock (rising edge), synchronous active-high reset
//   S_AXI_AW*             write address channel (AWPROT ignored)
//   S_AXI_W*              write data channel with byte strobes
//   S_AXI_B*              write response channel
//   S_AXI_AR*             read address channel (ARPROT ignored)
//   S_AXI_R*              read data channel
//   sum_out               registered low 32 bits of REG0+REG1
//   carry_out             registered carry of REG0+REG1
// -----------------------------------------------------------------------------
module sum_ip_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     sum_out,
    output logic                              carry_out
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef SUM_IP_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    // Handshake semantics on every channel: a transfer happens at the rising
    // edge where both VALID and READY are high. A VALID, once raised by this
    // block, stays high with its payload frozen until that transfer. All READY
    // and VALID outputs come straight from flops, so nothing on the bus is
    // combinationally dependent on the master's inputs.

    // Write path state
    logic                aw_full_q, aw_full_n;
    logic [2:0]          aw_idx_q, aw_idx_n;
    logic                w_full_q, w_full_n;
    logic [DW-1:0]       w_data_q, w_data_n;
    logic [NB-1:0]       w_strb_q, w_strb_n;
    logic                awready_q, awready_n;
    logic                wready_q, wready_n;
    logic                bvalid_q, bvalid_n;
    logic [1:0]          bresp_q, bresp_n;

    // Read path state
    logic                arready_q, arready_n;
    logic                rvalid_q, rvalid_n;
    logic [DW-1:0]       rdata_q, rdata_n;
    logic [1:0]          rresp_q, rresp_n;

    // Register bank and adder
    logic [3:0][DW-1:0]  regs_q, regs_n;
    logic [DW-1:0]       sum_q;
    logic                carry_q;
    logic [DW:0]         add_full;

    // Intermediate combinational signals
    logic                aw_hs, w_hs, ar_hs;
    logic                have_aw, have_w, commit;
    logic [2:0]          wr_idx;
    logic [DW-1:0]       wr_data;
    logic [NB-1:0]       wr_strb;
    logic [2:0]          rd_idx;
    logic [DW-1:0]       rd_word;
    logic [1:0]          rd_resp;

    // Protection bits and the byte-lane address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Full-width add so the carry is available as its own bit.
    assign add_full = {1'b0, regs_q[0]} + {1'b0, regs_q[1]};

    // Read mux on the current (pre-commit) register values, so a read and a
    // write landing on the same edge return the old contents.
    always_comb begin
        rd_idx  = S_AXI_ARADDR[4:2];
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (rd_idx)
            3'd0, 3'd1, 3'd2, 3'd3: rd_word = regs_q[rd_idx[1:0]];
            3'd4:                   rd_word = sum_q;
            3'd5:                   rd_word = {{(DW-1){1'b0}}, carry_q};
            default: begin
                rd_word = '0;
                rd_resp = RESP_UNMAPPED;
            end
        endcase
    end

    always_comb begin
        aw_full_n = aw_full_q;
        aw_idx_n  = aw_idx_q;
        w_full_n  = w_full_q;
        w_data_n  = w_data_q;
        w_strb_n  = w_strb_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        regs_n    = regs_q;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;

        aw_hs = S_AXI_AWVALID && awready_q;
        w_hs  = S_AXI_WVALID  && wready_q;
        ar_hs = S_AXI_ARVALID && arready_q;

        // Address and data are each usable either from their buffer or from
        // a handshake on this very edge; the write commits as soon as both are.
        have_aw = aw_full_q || aw_hs;
        have_w  = w_full_q  || w_hs;
        commit  = have_aw && have_w;

        wr_idx  = aw_full_q ? aw_idx_q : S_AXI_AWADDR[4:2];
        wr_data = w_full_q  ? w_data_q : S_AXI_WDATA;
        wr_strb = w_full_q  ? w_strb_q : S_AXI_WSTRB;

        if (aw_hs) begin
            aw_idx_n = S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
            w_data_n = S_AXI_WDATA;
            w_strb_n = S_AXI_WSTRB;
        end
        aw_full_n = have_aw && !commit;
        w_full_n  = have_w  && !commit;

        if (commit) begin
            // Indices 0..3 are the RW bank; 4/5 are read-only and 6/7 unmapped.
            if (!wr_idx[2]) begin
                for (int k = 0; k < NB; k++) begin
                    if (wr_strb[k]) begin
                        regs_n[wr_idx[1:0]][8*k +: 8] = wr_data[8*k +: 8];
                    end
                end
            end
            bvalid_n = 1'b1;
            bresp_n  = (wr_idx[2:1] == 2'b11) ? RESP_UNMAPPED : RESP_OKAY;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_n = 1'b0;
            bresp_n  = RESP_OKAY;
        end

        // Ready flops look one cycle ahead so they drop right after a capture
        // and stay low for the whole time a B response is outstanding.
        awready_n = !aw_full_n && !bvalid_n;
        wready_n  = !w_full_n  && !bvalid_n;

        if (ar_hs) begin
            rvalid_n = 1'b1;
            rdata_n  = rd_word;
            rresp_n  = rd_resp;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_n = 1'b0;
            rdata_n  = '0;
            rresp_n  = RESP_OKAY;
        end
        arready_n = !rvalid_n;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            regs_q    <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            aw_full_q <= aw_full_n;
            aw_idx_q  <= aw_idx_n;
            w_full_q  <= w_full_n;
            w_data_q  <= w_data_n;
            w_strb_q  <= w_strb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
            regs_q    <= regs_n;
            // Registered every cycle from the current operands, so it trails
            // an operand commit by one edge.
            sum_q     <= add_full[DW-1:0];
            carry_q   <= add_full[DW];
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign sum_out       = sum_q;
    assign carry_out     = carry_q;

endmodule

// File: tb/tb_sum_ip_axil_slave.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_sum_ip_axil_slave
//
// Directed bench for sum_ip_axil_slave: a table of bus writes/reads with
// hand-computed results, followed by hand-written multi-cycle sequences
// (W ahead of AW with a stalled B, same-edge read/write, reset mid-read).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sum_ip_axil_slave;

    localparam logic [1:0] OKAY = 2'b00;
`ifdef SUM_IP_SLVERR_EN
    localparam logic [1:0] EXP_UNMAP = 2'b10;
`else
    localparam logic [1:0] EXP_UNMAP = 2'b00;
`endif
    localparam int TIMEOUT = 50;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        areset;
    always #5 clk = ~clk;

    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] sum_out;
    logic        carry_out;

    sum_ip_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .ACLK          (clk),
        .ARESET        (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .sum_out       (sum_out),
        .carry_out     (carry_out)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no handshake within %0d cycles", name, TIMEOUT);
    endtask

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        resp    = 2'bxx;
        @(negedge clk);
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        bready  = 1'b1;
        while (!(aw_done && w_done) && cyc < TIMEOUT) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            timeout_fail("write_addr_data");
            bready = 1'b0;
            return;
        end
        cyc = 0;
        while (!bvalid && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        if (!bvalid) begin
            timeout_fail("write_resp");
            bready = 1'b0;
            return;
        end
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit ar_fire;
        int cyc;
        cyc     = 0;
        ar_fire = 0;
        data    = 'x;
        resp    = 2'bxx;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        while (!ar_fire && cyc < TIMEOUT) begin
            ar_fire = arvalid && arready;
            @(negedge clk);
            cyc++;
        end
        arvalid = 1'b0;
        if (!ar_fire) begin
            timeout_fail("read_addr");
            rready = 1'b0;
            return;
        end
        cyc = 0;
        while (!rvalid && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        if (!rvalid) begin
            timeout_fail("read_data");
            rready = 1'b0;
            return;
        end
        data = rdata;
        resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit is_wr, input logic [4:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [31:0] exp_data,
                                input logic [1:0] exp_resp);
        vec_t v;
        v.is_wr    = is_wr;
        v.addr     = addr;
        v.data     = data;
        v.strb     = strb;
        v.exp_data = exp_data;
        v.exp_resp = exp_resp;
        return v;
    endfunction

    // Watchdog: the directed flow is short, so this only fires on a hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;

        // Write 1..4, read back, then the carry case, byte strobes, unmapped.
        vecs.push_back(mk(1, 5'h00, 32'h0000_0001, 4'hF, 32'h0, OKAY));
        vecs.push_back(mk(1, 5'h04, 32'h0000_0002, 4'hF, 32'h0, OKAY));
        vecs.push_back(mk(1, 5'h08, 32'h0000_0003, 4'hF, 32'h0, OKAY));
        vecs.push_back(mk(1, 5'h0C, 32'h0000_0004, 4'hF, 32'h0, OKAY));
        vecs.push_back(mk(0, 5'h00, 32'h0, 4'h0, 32'h0000_0001, OKAY));
        vecs.push_back(mk(0, 5'h04, 32'h0, 4'h0, 32'h0000_0002, OKAY));
        vecs.push_back(mk(0, 5'h08, 32'h0, 4'h0, 32'h0000_0003, OKAY));
        vecs.push_back(mk(0, 5'h0C, 32'h0, 4'h0, 32'h0000_0004, OKAY));
        vecs.push_back(mk(0, 5'h10, 32'h0, 4'h0, 32'h0000_0003, OKAY));
        vecs.push_back(mk(0, 5'h14, 32'h0, 4'h0, 32'h0000_0000, OKAY));
        vecs.push_back(mk(1, 5'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, OKAY));
        vecs.push_back(mk(1, 5'h04, 32'h0000_0002, 4'hF, 32'h0, OKAY));
        vecs.push_back(mk(0, 5'h10, 32'h0, 4'h0, 32'h0000_0001, OKAY));
        vecs.push_back(mk(0, 5'h14, 32'h0, 4'h0, 32'h0000_0001, OKAY));
        vecs.push_back(mk(1, 5'h08, 32'h1122_3344, 4'hF, 32'h0, OKAY));
        vecs.push_back(mk(1, 5'h08, 32'hAABB_CCDD, 4'h5, 32'h0, OKAY));
        vecs.push_back(mk(0, 5'h08, 32'h0, 4'h0, 32'h11BB_33DD, OKAY));
        vecs.push_back(mk(1, 5'h10, 32'h1234_5678, 4'hF, 32'h0, OKAY));
        vecs.push_back(mk(0, 5'h10, 32'h0, 4'h0, 32'h0000_0001, OKAY));
        vecs.push_back(mk(1, 5'h18, 32'h0000_0001, 4'hF, 32'h0, EXP_UNMAP));
        vecs.push_back(mk(0, 5'h1C, 32'h0, 4'h0, 32'h0000_0000, EXP_UNMAP));
        vecs.push_back(mk(0, 5'h00, 32'h0, 4'h0, 32'hFFFF_FFFF, OKAY));
        vecs.push_back(mk(0, 5'h07, 32'h0, 4'h0, 32'h0000_0002, OKAY));
        vecs.push_back(mk(0, 5'h08, 32'h0, 4'h0, 32'h11BB_33DD, OKAY));
        vecs.push_back(mk(0, 5'h0C, 32'h0, 4'h0, 32'h0000_0004, OKAY));

        // ---------------- reset ----------------
        areset  = 1'b1;
        awaddr  = '0; awprot = '0; awvalid = 1'b0;
        wdata   = '0; wstrb  = '0; wvalid  = 1'b0; bready = 1'b0;
        araddr  = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_handshake_outs", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check("reset_resps", {28'd0, bresp, rresp}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_sum", sum_out, 32'd0);
        check("reset_carry", {31'd0, carry_out}, 32'd0);
        areset = 1'b0;
        @(negedge clk);
        check("idle_readies", {29'd0, awready, wready, arready}, 32'd7);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                check($sformatf("vec%0d_bresp", i), {30'd0, rs}, {30'd0, vecs[i].exp_resp});
            end else begin
                axi_read(vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), {30'd0, rs}, {30'd0, vecs[i].exp_resp});
            end
        end
        check("port_sum_carry_case", sum_out, 32'h0000_0001);
        check("port_carry", {31'd0, carry_out}, 32'd1);

        // ---------------- W two cycles ahead of AW, B stalled ----------------
        @(negedge clk);
        wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        check("wfirst_wready_idle", {31'd0, wready}, 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        check("wfirst_wready_drop", {31'd0, wready}, 32'd0);
        check("wfirst_no_bvalid", {31'd0, bvalid}, 32'd0);
        @(negedge clk);
        check("wfirst_no_bvalid2", {31'd0, bvalid}, 32'd0);
        awaddr = 5'h08; awvalid = 1'b1;
        check("wfirst_awready", {31'd0, awready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bstall%0d_bvalid", c), {31'd0, bvalid}, 32'd1);
            check($sformatf("bstall%0d_readies", c), {30'd0, awready, wready}, 32'd0);
            if (c < 2) @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bstall_bvalid_clear", {31'd0, bvalid}, 32'd0);
        check("bstall_readies_back", {30'd0, awready, wready}, 32'd3);
        axi_read(5'h08, rd, rs);
        check("wfirst_readback", rd, 32'hA5A5_A5A5);

        // ---------------- same-edge read and write to REG3 ----------------
        @(negedge clk);
        awaddr = 5'h0C; awvalid = 1'b1;
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 5'h0C; arvalid = 1'b1;
        bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_edge_both_valid", {30'd0, bvalid, rvalid}, 32'd3);
        check("same_edge_old_data", rdata, 32'h0000_0004);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        check("same_edge_both_clear", {30'd0, bvalid, rvalid}, 32'd0);
        axi_read(5'h0C, rd, rs);
        check("same_edge_new_data", rd, 32'hDEAD_BEEF);

        // ---------------- reset while a read response is stalled ----------------
        @(negedge clk);
        araddr = 5'h00; arvalid = 1'b1; rready = 1'b0;
        wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; wvalid = 1'b0;
        check("midreset_rvalid_pending", {31'd0, rvalid}, 32'd1);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        check("midreset_rvalid_drop", {31'd0, rvalid}, 32'd0);
        check("midreset_readies_low", {29'd0, awready, wready, arready}, 32'd0);
        @(negedge clk);
        check("midreset_sum_zero", sum_out, 32'd0);
        check("midreset_carry_zero", {31'd0, carry_out}, 32'd0);
        check("midreset_no_resp_owed", {30'd0, bvalid, rvalid}, 32'd0);
        axi_read(5'h00, rd, rs);
        check("midreset_reg0_zero", rd, 32'd0);
        axi_write(5'h04, 32'h0000_0007, 4'hF, rs);
        check("midreset_write_bresp", {30'd0, rs}, 32'd0);
        axi_read(5'h04, rd, rs);
        check("midreset_reg1_fresh", rd, 32'h0000_0007);
        axi_read(5'h0C, rd, rs);
        check("midreset_reg3_zero", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
